// File: rtl/mult_pkg.sv
// Shared types and sizing helpers for the sequential shift-add multiplier.
// Imported by the controller and the datapath top.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD   = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } mult_state_t;

  // Iteration counter width; a counter that covers 0..w-1.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/mult_step_ctrl.sv
// Control FSM and iteration counter for shift_add_mult.
// Emits one-hot datapath strobes decoded from the registered state.
module mult_step_ctrl
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Run,
  input  logic ClearA_LoadB,
  input  logic B0,
  output logic ld_b,
  output logic start,
  output logic do_add,
  output logic do_sub,
  output logic do_shift,
  output logic Busy,
  output logic Done
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  mult_state_t     state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            last;

  assign last = (cnt_q == LAST);

  // Load has priority over start, so a held ClearA_LoadB defers the run.
  assign ld_b     = (state_q == IDLE) && ClearA_LoadB;
  assign start    = (state_q == IDLE) && Run && !ClearA_LoadB;
  // do_sub marks the final partial product; the datapath only subtracts in signed mode.
  assign do_add   = (state_q == ADD) && B0 && !last;
  assign do_sub   = (state_q == ADD) && B0 && last;
  assign do_shift = (state_q == SHIFT);
  assign Busy     = (state_q == ADD) || (state_q == SHIFT);
  assign Done     = (state_q == HOLD);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ADD;
          cnt_d   = '0;
        end
      end
      ADD:   state_d = SHIFT;
      SHIFT: begin
        if (last) begin
          state_d = HOLD;
        end else begin
          state_d = ADD;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (!Run) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/shift_add_mult.sv
// Sequential WIDTHxWIDTH shift-add multiplier (unsigned or two's-complement).
// Product lands in {A,B} after 2*WIDTH cycles and is held until Run drops.
module shift_add_mult
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Run,
  input  logic             ClearA_LoadB,
  input  logic             Signed_Mode,
  input  logic [WIDTH-1:0] Din,
  output logic [WIDTH-1:0] Aval,
  output logic [WIDTH-1:0] Bval,
  output logic             Xval,
  output logic             Busy,
  output logic             Done
);

  logic             x_q, x_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic             sgn_q, sgn_d;

  logic ld_b, start, do_add, do_sub, do_shift;

  mult_step_ctrl #(.WIDTH(WIDTH)) u_ctrl (
    .Clk          (Clk),
    .Reset        (Reset),
    .Run          (Run),
    .ClearA_LoadB (ClearA_LoadB),
    .B0           (b_q[0]),
    .ld_b         (ld_b),
    .start        (start),
    .do_add       (do_add),
    .do_sub       (do_sub),
    .do_shift     (do_shift),
    .Busy         (Busy),
    .Done         (Done)
  );

  // One extra bit of headroom so the add/subtract can never overflow.
  logic [WIDTH:0] a_ext, m_ext, sum;
  logic           sub;

  assign a_ext = {sgn_q & a_q[WIDTH-1], a_q};
  assign m_ext = {sgn_q & m_q[WIDTH-1], m_q};
  // The multiplier's sign bit carries negative weight only in signed mode.
  assign sub   = do_sub & sgn_q;
  assign sum   = sub ? (a_ext - m_ext) : (a_ext + m_ext);

  always_comb begin
    x_d   = x_q;
    a_d   = a_q;
    b_d   = b_q;
    m_d   = m_q;
    sgn_d = sgn_q;
    if (ld_b) begin
      x_d = 1'b0;
      a_d = '0;
      b_d = Din;
    end
    if (start) begin
      m_d   = Din;
      sgn_d = Signed_Mode;
      x_d   = 1'b0;
      a_d   = '0;
    end
    if (do_add || do_sub) begin
      a_d = sum[WIDTH-1:0];
      x_d = sum[WIDTH];
    end
    if (do_shift) begin
      x_d = sgn_q & x_q;
      a_d = {x_q, a_q[WIDTH-1:1]};
      b_d = {a_q[0], b_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      x_q   <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      m_q   <= '0;
      sgn_q <= 1'b0;
    end else begin
      x_q   <= x_d;
      a_q   <= a_d;
      b_q   <= b_d;
      m_q   <= m_d;
      sgn_q <= sgn_d;
    end
  end

  assign Aval = a_q;
  assign Bval = b_q;
  assign Xval = x_q;

endmodule

// File: doc/shift_add_mult.md
# shift_add_mult

Parametrised sequential shift-add multiplier: control FSM, iteration counter and X/A/B datapath in one block. Computes a WIDTH×WIDTH product in 2·WIDTH cycles, in unsigned or two's-complement mode, and holds the result until Run is released. It sits between the switch/button synchroniser and the hex-display driver, replacing the fixed 8-bit, per-step-state controller.

## Interface
- WIDTH, 8: operand width in bits; legal range 4..32.
- Clk  in  1  clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-high.
- Run  in  1  level start request, synchronised and debounced upstream.
- ClearA_LoadB  in  1  level; in IDLE: clear X and A, load B from Din.
- Signed_Mode  in  1  1 = two's-complement, 0 = unsigned; captured at start.
- Din  in  WIDTH  operand switches; supplies B on load and the multiplicand at start.
- Aval  out  WIDTH  A register (product upper half).
- Bval  out  WIDTH  B register (product lower half).
- Xval  out  1  X extension bit.
- Busy  out  1  high in ADD and SHIFT.
- Done  out  1  high in HOLD.

## Operation
- States: IDLE, ADD, SHIFT, HOLD. Counter cnt, width $clog2(WIDTH), counts 0..WIDTH-1.
- IDLE with ClearA_LoadB=1: X←0, A←0, B←Din. ClearA_LoadB takes priority over Run; start is deferred while it is high.
- IDLE with Run=1 and ClearA_LoadB=0: M←Din, sgn←Signed_Mode, X←0, A←0, cnt←0, then go to ADD. B keeps its loaded value.
- ADD with B[0]=1: form a (WIDTH+1)-bit result r from A and M. Extension is sign extension if sgn=1, zero extension otherwise.
  - r = A − M when sgn=1 and cnt=WIDTH-1.
  - r = A + M in all other cases.
  - A←r[WIDTH-1:0], X←r[WIDTH].
- ADD with B[0]=0: A and X are unchanged. ADD always goes to SHIFT.
- SHIFT: {X,A,B}←{X,A,B}>>1.
  - Arithmetic shift if sgn=1 (X is retained).
  - Logical shift if sgn=0 (X←0).
  - If cnt=WIDTH-1, go to HOLD; otherwise cnt←cnt+1 and go to ADD.
- HOLD: all registers are frozen. The product is {A,B} (2·WIDTH bits). Go to IDLE when Run=0.
- In ADD, SHIFT and HOLD, changes on Run (other than release in HOLD), ClearA_LoadB, Signed_Mode and Din are ignored.

## Timing
- Reset, asynchronous: state=IDLE, cnt=0, X=0, A=0, B=0, M=0, sgn=0. Outputs: Aval=0, Bval=0, Xval=0, Busy=0, Done=0.
- Reset asserted mid-operation aborts immediately. No partial result is retained.
- Start sampled at edge t0 → first ADD in cycle t0+1. Done=1 after edge t0+2·WIDTH, i.e. 2·WIDTH+1 cycles after Run is sampled.
- Busy and Done are Moore outputs decoded from the registered state and are never high together.
- Run held high through HOLD produces exactly one multiplication. A new multiplication requires Run low for at least one cycle, then high again.
- HOLD→IDLE takes 1 cycle after Run=0 is sampled. The result stays visible in IDLE until the next load or start.
- Arithmetic for the add/subtract step is done at WIDTH+1 bits, so no overflow is possible. X is always bit WIDTH of that result.

## Structure
- Package mult_pkg holds:
  - the state enum `mult_state_t` {IDLE, ADD, SHIFT, HOLD} as logic [1:0];
  - a `cnt_width(WIDTH)` helper or localparam convention.
- Sub-module mult_step_ctrl (parameter WIDTH):
  - contents: FSM and cnt;
  - inputs: Run, ClearA_LoadB, B0;
  - outputs: ld_b, start, do_add, do_sub, do_shift, Busy, Done.
- The top level holds the X/A/B/M registers, the (WIDTH+1)-bit adder/subtractor and the shifter.

## Test plan
- WIDTH=8, unsigned, B=0xFF, Din=0xFF at start → after 16 cycles: Done=1, {A,B}=0xFE01, X=0.
- WIDTH=8, signed, B=0xFF, M=0x07 → {A,B}=0xFFF9 (−7).
- WIDTH=8, signed, B=0x80, M=0x80 → {A,B}=0x4000. Final subtract step: X=0 and A=0x80 before the last shift.
- WIDTH=8, B=0x05, M=0x03, Run held high for 40 cycles → Done stays 1, exactly one product 0x000F. Drop Run, reassert → product is 0x000F again (A cleared at start, no accumulation).
- WIDTH=8, Reset pulsed in cycle 6 of an operation → all outputs 0, state IDLE. A following load and run produce a correct product.
- WIDTH=16, signed, B=0x0002, M=0x8000 → Done after 32 cycles, {A,B}=0xFFFF0000. Busy is high for exactly 32 cycles.
